sign_narrow: RTL
================

# sign_narrow

Streaming signed-narrowing unit: converts IN_W-bit two's-complement values to OUT_W bits, the inverse of sign extension. It flags any value that does not fit and either saturates or wraps it. It sits between the datapath result bus and narrow destinations (byte/nibble stores, packed immediates). It is a 2-stage valid/ready pipeline with a sticky overflow flag and a saturating overflow event counter.

## Interface
Parameters:
- IN_W, 8, input width (bits)
- OUT_W, 4, output width; legal range 1 ≤ OUT_W < IN_W
- CNT_W, 8, overflow counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  unit can accept a sample
- in_data  in  IN_W  signed input sample
- mode  in  1  0 = saturate, 1 = wrap; sampled with in_data on acceptance
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  OUT_W  narrowed signed result
- out_ovf  out  1  this sample did not fit in OUT_W
- ovf_sticky  out  1  set by any delivered overflow sample; held until cleared
- ovf_cnt  out  CNT_W  count of delivered overflow samples, saturating
- clr  in  1  clears ovf_sticky and ovf_cnt

## Operation
- Fit test: the sample fits if bits [IN_W-1:OUT_W-1] of in_data are all equal. Otherwise out_ovf = 1.
- Saturate mode with overflow:
  - positive input (MSB = 0) → 0 followed by all ones (max)
  - negative input → 1 followed by all zeros (min)
- Wrap mode, or any sample that fits: out_data = in_data[OUT_W-1:0].
- Stage 1 registers in_data, mode and the fit result. Stage 2 registers out_data and out_ovf.
- Ready chain:
  - stage 2 advances when it is empty or out_ready = 1
  - stage 1 advances when it is empty or stage 2 advances
  - in_ready = stage-1 advance condition
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Statistics update only on an output handshake with out_ovf = 1:
  - ovf_sticky is set
  - ovf_cnt increments and holds at 2^CNT_W−1
- clr in the same cycle as a counted event:
  - ovf_sticky ends at 1 (set wins)
  - ovf_cnt ends at 1 (clear first, then count)
- A mode change affects only samples accepted after the change. Samples already in flight keep their captured mode.

## Timing
- Reset values:
  - in_ready = 0 during reset, 1 in the first cycle after reset
  - out_valid = 0, out_data = 0, out_ovf = 0
  - ovf_sticky = 0, ovf_cnt = 0
- Latency: a sample accepted in cycle N appears with out_valid = 1 in cycle N+2.
- Throughput: one sample per cycle while out_ready = 1.
- Backpressure:
  - with out_ready held 0, at most 2 samples are buffered; in_ready falls after the second acceptance
  - in_ready rises in the same cycle out_ready returns to 1 (combinational path from out_ready to in_ready is permitted)
- While out_valid = 1 and out_ready = 0, out_data and out_ovf stay stable.
- Order is preserved. No sample is dropped or duplicated.
- Reset mid-operation: both stages are emptied and buffered samples discarded. Statistics clear in the same cycle.
- ovf_sticky and ovf_cnt are registered and reflect a handshake one cycle after it.

## Structure
- Package sign_pkg holds:
  - the mode encoding constants MODE_SAT = 0 and MODE_WRAP = 1
  - a helper function for the saturation limits of a given width
- Sub-module narrow_classify: purely combinational fit test plus saturate/wrap select, parameterised on IN_W/OUT_W.
- Top level sign_narrow holds the two pipeline stages, the handshake logic and the statistics.

## Test plan
All scenarios use the defaults IN_W = 8, OUT_W = 4 (legal range −8..7).
- In-range and boundary fits: 0x05 → 0x5, ovf 0; 0xF8 → 0x8, ovf 0; 0x07 → 0x7, ovf 0. Each appears 2 cycles after acceptance.
- Saturate mode (mode = 0): 0x7F → 0x7, ovf 1; 0x80 → 0x8, ovf 1; 0xF7 → 0x8, ovf 1.
- Wrap mode (mode = 1): 0x7F → 0xF, ovf 1; 0x80 → 0x0, ovf 1; 0xF7 → 0x7, ovf 1.
- Backpressure:
  - stimulus: out_ready = 0 for 6 cycles while 4 samples are offered
  - response: exactly 2 accepted, in_ready = 0 after that
  - response after releasing out_ready: all 4 delivered in order, none lost
- Statistics:
  - 300 back-to-back overflow samples → ovf_cnt = 255, ovf_sticky = 1
  - clr coinciding with an overflow handshake → ovf_cnt = 1, ovf_sticky = 1
- Reset mid-stream: assert rst with 2 samples buffered → next cycle out_valid = 0, ovf_cnt = 0; then in_ready = 1 once rst drops.

Source files
------------

// File: rtl/sign_pkg.sv
// Shared definitions for the signed-narrowing unit: mode encoding and the
// saturation-limit helper used to build the clamp constants.
package sign_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Wide enough for any practical output width; callers keep the low bits.
    localparam int unsigned LIMIT_W = 64;
    localparam logic [LIMIT_W-1:0] LIMIT_ONE = {{(LIMIT_W-1){1'b0}}, 1'b1};

    // Most positive (negative = 0) or most negative (negative = 1) two's
    // complement value representable in 'width' bits, zero/one extended.
    function automatic logic [LIMIT_W-1:0] sat_limit(input int unsigned width,
                                                     input logic        negative);
        logic [LIMIT_W-1:0] msb_only;
        msb_only = LIMIT_ONE << (width - 1);
        if (negative) begin
            return ~(msb_only - LIMIT_ONE);
        end
        return msb_only - LIMIT_ONE;
    endfunction

endpackage

// File: rtl/narrow_classify.sv
// Combinational fit test for an incoming sample and the saturate/wrap select
// applied to a sample already captured in the first pipeline stage.
module narrow_classify
    import sign_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-OUT_W:0] check_bits,
    output logic                fits,
    input  logic                sel_sign,
    input  logic [OUT_W-1:0]    sel_low,
    input  logic                sel_mode,
    input  logic                sel_fits,
    output logic [OUT_W-1:0]    result
);

    localparam logic [LIMIT_W-1:0] MAX_FULL = sat_limit(OUT_W, 1'b0);
    localparam logic [LIMIT_W-1:0] MIN_FULL = sat_limit(OUT_W, 1'b1);
    localparam logic [OUT_W-1:0]   MAX_VAL  = MAX_FULL[OUT_W-1:0];
    localparam logic [OUT_W-1:0]   MIN_VAL  = MIN_FULL[OUT_W-1:0];

    // check_bits holds in_data[IN_W-1:OUT_W-1]; the value fits only when
    // every one of those bits is a copy of the sign bit.
    logic [IN_W-OUT_W-1:0] same_as_sign;

    generate
        for (genvar gi = 0; gi < IN_W - OUT_W; gi++) begin : g_sign_cmp
            assign same_as_sign[gi] = (check_bits[gi] == check_bits[IN_W-OUT_W]);
        end
    endgenerate

    assign fits = &same_as_sign;

    always_comb begin
        result = sel_low;
        if (!sel_fits && (sel_mode == MODE_SAT)) begin
            result = sel_sign ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// Two-stage valid/ready pipeline narrowing signed IN_W-bit samples to OUT_W
// bits, with per-sample overflow flag, sticky overflow and saturating counter.
module sign_narrow
    import sign_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Stage 1 keeps only the bits of in_data that matter once the fit test
    // is done: the sign and the low OUT_W bits.
    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [OUT_W-1:0] s1_low_reg;
    logic             s1_mode_reg;
    logic             s1_fits_reg;

    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic             out_ovf_reg;
    logic             sticky_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             ovf_event;
    logic             in_fits;
    logic [OUT_W-1:0] narrowed;

    assign s2_adv    = ~out_valid_reg | out_ready;
    assign s1_adv    = ~s1_valid_reg | s2_adv;
    assign in_ready  = s1_adv & ~rst;
    assign accept    = in_valid & in_ready;
    assign ovf_event = out_valid_reg & out_ready & out_ovf_reg;

    narrow_classify #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_classify (
        .check_bits (in_data[IN_W-1:OUT_W-1]),
        .fits       (in_fits),
        .sel_sign   (s1_sign_reg),
        .sel_low    (s1_low_reg),
        .sel_mode   (s1_mode_reg),
        .sel_fits   (s1_fits_reg),
        .result     (narrowed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_sign_reg   <= 1'b0;
            s1_low_reg    <= '0;
            s1_mode_reg   <= MODE_SAT;
            s1_fits_reg   <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= narrowed;
                    out_ovf_reg  <= ~s1_fits_reg;
                end
            end
            if (s1_adv) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_sign_reg <= in_data[IN_W-1];
                    s1_low_reg  <= in_data[OUT_W-1:0];
                    s1_mode_reg <= mode;
                    s1_fits_reg <= in_fits;
                end
            end
        end
    end

    // A clear in the same cycle as a counted event leaves exactly that event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (clr) begin
            sticky_reg <= ovf_event;
            cnt_reg    <= ovf_event ? CNT_ONE : '0;
        end else if (ovf_event) begin
            sticky_reg <= 1'b1;
            if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_ovf    = out_ovf_reg;
    assign ovf_sticky = sticky_reg;
    assign ovf_cnt    = cnt_reg;

endmodule
